// File: rtl/core_msg_frontend_pkg.sv
// Shared definitions for the per-core scheduler message front end.
package core_msg_frontend_pkg;

  localparam int unsigned SCHED_MSG_BUS_WIDTH = 16;

  typedef enum logic [1:0] {
    FE_IDLE,
    FE_R0,
    FE_FETCH,
    FE_EXEC
  } fe_state_e;

endpackage

// File: rtl/core_ibuf.sv
// Instruction FIFO: flushable, with count output and accepted push when full if a pop coincides.
module core_ibuf #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned WIDTH = 16
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       flush,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  output logic                       head_valid,
  output logic [WIDTH-1:0]           head_data,
  output logic                       full,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    rptr_q, wptr_q;
  logic [AW:0]      count_q;
  logic             pop_eff, push_eff;

  assign head_valid = (count_q != '0);
  assign head_data  = head_valid ? mem[rptr_q] : '0;
  assign full       = (count_q == (AW+1)'(DEPTH));
  assign count      = count_q;
  assign pop_eff    = pop && head_valid;
  assign push_eff   = push && (!full || pop_eff);

  always_ff @(posedge clk) begin
    if (push_eff && !flush) mem[wptr_q] <= push_data;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rptr_q  <= '0;
      wptr_q  <= '0;
      count_q <= '0;
    end else if (flush) begin
      rptr_q  <= '0;
      wptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (push_eff) wptr_q <= wptr_q + 1'b1;
      if (pop_eff)  rptr_q <= rptr_q + 1'b1;
      if (push_eff && !pop_eff)      count_q <= count_q + 1'b1;
      else if (pop_eff && !push_eff) count_q <= count_q - 1'b1;
    end
  end

endmodule

// File: rtl/core_msg_frontend.sv
// Per-core receiver for the scheduler broadcast bus: task-start decode, R0 writes and
// instruction buffering with bus backpressure.
module core_msg_frontend
  import core_msg_frontend_pkg::*;
#(
  parameter int unsigned CORE_ID    = 0,
  parameter int unsigned CORE_NUM   = 16,
  parameter int unsigned BUS_W      = SCHED_MSG_BUS_WIDTH,
  parameter int unsigned R0_DEPTH   = 8,
  parameter int unsigned IBUF_DEPTH = 16
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic [BUS_W-1:0]            mess_to_core,
  input  logic                        core_mask_loading,
  input  logic                        r0_mask_loading,
  input  logic                        r0_loading,
  input  logic                        instr_loading,
  output logic                        core_reading,
  output logic                        core_ready,
  output logic                        r0_wr_en,
  output logic [$clog2(R0_DEPTH)-1:0] r0_wr_addr,
  output logic [BUS_W-1:0]            r0_wr_data,
  output logic                        instr_valid,
  output logic [BUS_W-1:0]            instr_data,
  input  logic                        instr_ready,
  input  logic                        exec_done,
  output logic                        err
);

  localparam int unsigned SEL_BIT = CORE_ID % CORE_NUM;
  localparam int unsigned R0AW    = $clog2(R0_DEPTH);
  localparam int unsigned IDXW    = $clog2(R0_DEPTH + 1);
  localparam int unsigned CW      = $clog2(IBUF_DEPTH) + 1;

  fe_state_e       state;
  logic [IDXW-1:0] r0_idx;
  logic            r0_sel;
  logic [2:0]      nflags;
  logic            multi, my_bit, push, pop, full, overflow;
  logic [CW-1:0]   count;

  assign nflags = {2'b0, core_mask_loading} + {2'b0, r0_mask_loading}
                + {2'b0, r0_loading} + {2'b0, instr_loading};
  assign multi  = (nflags > 3'd1);
  assign my_bit = mess_to_core[SEL_BIT];
  assign pop    = instr_valid && instr_ready;
  assign push   = !multi && instr_loading && !exec_done
                && ((state == FE_R0) || (state == FE_FETCH));
  assign overflow = push && full && !pop;

  // One slot of headroom covers the beat already in flight from the scheduler.
  assign core_reading = ((state == FE_IDLE) || (state == FE_EXEC))
                      || (count <= CW'(IBUF_DEPTH - 2));

  core_ibuf #(
    .DEPTH(IBUF_DEPTH),
    .WIDTH(BUS_W)
  ) u_ibuf (
    .clk       (clk),
    .reset_n   (reset_n),
    .flush     (exec_done && (state != FE_IDLE)),
    .push      (push),
    .push_data (mess_to_core),
    .pop       (instr_ready),
    .head_valid(instr_valid),
    .head_data (instr_data),
    .full      (full),
    .count     (count)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= FE_IDLE;
      core_ready <= 1'b1;
      r0_idx     <= '0;
      r0_sel     <= 1'b0;
      r0_wr_en   <= 1'b0;
      r0_wr_addr <= '0;
      r0_wr_data <= '0;
      err        <= 1'b0;
    end else begin
      r0_wr_en <= 1'b0;
      if (multi || overflow) err <= 1'b1;
      if (exec_done && (state != FE_IDLE)) begin
        state      <= FE_IDLE;
        core_ready <= 1'b1;
      end else if (!multi) begin
        case (state)
          FE_IDLE: begin
            if (core_mask_loading && my_bit) begin
              state      <= FE_R0;
              core_ready <= 1'b0;
              r0_idx     <= '0;
              r0_sel     <= 1'b0;
            end
          end
          FE_R0: begin
            if (r0_mask_loading) r0_sel <= my_bit;
            if (r0_loading && r0_sel) begin
              if (r0_idx == IDXW'(R0_DEPTH)) begin
                err <= 1'b1;
              end else begin
                r0_wr_en   <= 1'b1;
                r0_wr_addr <= r0_idx[R0AW-1:0];
                r0_wr_data <= mess_to_core;
                r0_idx     <= r0_idx + 1'b1;
              end
            end
            if (instr_loading) state <= FE_FETCH;
          end
          FE_FETCH: begin
            if (core_mask_loading) begin
              if (my_bit) err <= 1'b1;
              else        state <= FE_EXEC;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_core_msg_frontend.sv
// Scoreboard bench for core_msg_frontend with CORE_ID=3.
module tb_core_msg_frontend;

  localparam int unsigned BUS_W = 16;
  localparam logic [3:0] F_CM = 4'b1000;
  localparam logic [3:0] F_RM = 4'b0100;
  localparam logic [3:0] F_R0 = 4'b0010;
  localparam logic [3:0] F_IN = 4'b0001;
  localparam logic [39:0] RST_EXP = {1'b1, 1'b1, 38'b0};

  logic             clk = 1'b0;
  logic             reset_n = 1'b0;
  logic [BUS_W-1:0] mess_to_core = '0;
  logic             core_mask_loading = 1'b0, r0_mask_loading = 1'b0;
  logic             r0_loading = 1'b0, instr_loading = 1'b0;
  logic             core_reading, core_ready, r0_wr_en;
  logic [2:0]       r0_wr_addr;
  logic [BUS_W-1:0] r0_wr_data, instr_data;
  logic             instr_valid, err;
  logic             instr_ready = 1'b1;
  logic             exec_done = 1'b0;

  int errors = 0;
  int checks = 0;
  logic [18:0] r0_q[$];
  logic [15:0] in_q[$];
  logic [18:0] mon_r0_exp;
  logic [15:0] mon_in_exp;
  logic [39:0] rst_got;

  core_msg_frontend #(
    .CORE_ID(3), .CORE_NUM(16), .BUS_W(BUS_W), .R0_DEPTH(8), .IBUF_DEPTH(16)
  ) dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .mess_to_core     (mess_to_core),
    .core_mask_loading(core_mask_loading),
    .r0_mask_loading  (r0_mask_loading),
    .r0_loading       (r0_loading),
    .instr_loading    (instr_loading),
    .core_reading     (core_reading),
    .core_ready       (core_ready),
    .r0_wr_en         (r0_wr_en),
    .r0_wr_addr       (r0_wr_addr),
    .r0_wr_data       (r0_wr_data),
    .instr_valid      (instr_valid),
    .instr_data       (instr_data),
    .instr_ready      (instr_ready),
    .exec_done        (exec_done),
    .err              (err)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not complete, required finish");
    $fatal(1, "timeout");
  end

  // Output monitor: every R0 write and every instruction pop is matched against the queues.
  always @(negedge clk) begin
    if (reset_n) begin
      if (r0_wr_en) begin
        checks++;
        if (r0_q.size() == 0) begin
          errors++;
          $display("FAIL r0_write: got addr=%0d data=%h, required no write", r0_wr_addr, r0_wr_data);
        end else begin
          mon_r0_exp = r0_q.pop_front();
          if ({r0_wr_addr, r0_wr_data} !== mon_r0_exp) begin
            errors++;
            $display("FAIL r0_write: got addr=%0d data=%h, required addr=%0d data=%h",
                     r0_wr_addr, r0_wr_data, mon_r0_exp[18:16], mon_r0_exp[15:0]);
          end
        end
      end
      if (instr_valid && instr_ready) begin
        checks++;
        if (in_q.size() == 0) begin
          errors++;
          $display("FAIL instr_pop: got %h, required no instruction", instr_data);
        end else begin
          mon_in_exp = in_q.pop_front();
          if (instr_data !== mon_in_exp) begin
            errors++;
            $display("FAIL instr_pop: got %h, required %h", instr_data, mon_in_exp);
          end
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic [3:0] f, input logic [15:0] d);
    {core_mask_loading, r0_mask_loading, r0_loading, instr_loading} = f;
    mess_to_core = d;
    step();
    {core_mask_loading, r0_mask_loading, r0_loading, instr_loading} = 4'b0;
    mess_to_core = '0;
  endtask

  task automatic pulse_done();
    exec_done = 1'b1;
    step();
    exec_done = 1'b0;
  endtask

  task automatic wait_empty(input string name);
    for (int i = 0; i < 40 && (r0_q.size() != 0 || in_q.size() != 0); i++) step();
    repeat (3) step();
    checks++;
    if (r0_q.size() != 0 || in_q.size() != 0) begin
      errors++;
      $display("FAIL %s_drain: got %0d r0 and %0d instr outstanding, required 0 and 0",
               name, r0_q.size(), in_q.size());
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (2) step();
    rst_got = {core_ready, core_reading, r0_wr_en, r0_wr_addr, r0_wr_data, instr_valid,
               instr_data, err};
    checks++;
    if (rst_got !== RST_EXP) begin
      errors++;
      $display("FAIL reset_values: got %h, required %h", rst_got, RST_EXP);
    end
    reset_n = 1'b1;
    step();
    checks++;
    if (core_ready !== 1'b1 || core_reading !== 1'b1 || instr_valid !== 1'b0) begin
      errors++;
      $display("FAIL after_reset: got ready=%b reading=%b valid=%b, required 1 1 0",
               core_ready, core_reading, instr_valid);
    end
  endtask

  task automatic test_select_load();
    instr_ready = 1'b1;
    beat(F_CM, 16'h0008);
    checks++;
    if (core_ready !== 1'b0) begin
      errors++;
      $display("FAIL select_ready_fall: got %b, required 0", core_ready);
    end
    beat(F_RM, 16'h0008);
    for (int i = 0; i < 8; i++) begin
      r0_q.push_back({3'(i), 16'(16'h00A0 + i)});
      beat(F_R0, 16'(16'h00A0 + i));
    end
    in_q.push_back(16'h1111);
    beat(F_IN, 16'h1111);
    in_q.push_back(16'h2222);
    beat(F_IN, 16'h2222);
    wait_empty("select_load");
    checks++;
    if (core_ready !== 1'b0) begin
      errors++;
      $display("FAIL select_busy: got %b, required 0", core_ready);
    end
    pulse_done();
    checks++;
    if (core_ready !== 1'b1) begin
      errors++;
      $display("FAIL done_ready_rise: got %b, required 1", core_ready);
    end
  endtask

  task automatic test_not_selected();
    beat(F_CM, 16'h0004);
    beat(F_RM, 16'h0004);
    for (int i = 0; i < 3; i++) beat(F_R0, 16'(16'h00C0 + i));
    for (int i = 0; i < 2; i++) begin
      beat(F_IN, 16'(16'h0C00 + i));
      checks++;
      if (core_ready !== 1'b1 || core_reading !== 1'b1) begin
        errors++;
        $display("FAIL not_selected_status: got ready=%b reading=%b, required 1 1",
                 core_ready, core_reading);
      end
    end
    wait_empty("not_selected");
  endtask

  task automatic test_r0_mask_clear();
    beat(F_CM, 16'h0008);
    beat(F_RM, 16'h0000);
    for (int i = 0; i < 8; i++) beat(F_R0, 16'(16'h00D0 + i));
    in_q.push_back(16'h3333);
    beat(F_IN, 16'h3333);
    in_q.push_back(16'h4444);
    beat(F_IN, 16'h4444);
    wait_empty("r0_mask_clear");
    checks++;
    if (err !== 1'b0) begin
      errors++;
      $display("FAIL r0_mask_clear_err: got %b, required 0", err);
    end
    pulse_done();
    // Flush: a held word must vanish on exec_done.
    instr_ready = 1'b0;
    beat(F_CM, 16'h0008);
    beat(F_IN, 16'h9999);
    checks++;
    if (instr_valid !== 1'b1 || instr_data !== 16'h9999) begin
      errors++;
      $display("FAIL flush_hold: got valid=%b data=%h, required 1 9999", instr_valid, instr_data);
    end
    pulse_done();
    checks++;
    if (instr_valid !== 1'b0 || core_ready !== 1'b1) begin
      errors++;
      $display("FAIL flush_empty: got valid=%b ready=%b, required 0 1", instr_valid, core_ready);
    end
    instr_ready = 1'b1;
    repeat (3) step();
  endtask

  task automatic test_backpressure();
    logic s1, s2;
    int   cnt, offered;
    instr_ready = 1'b0;
    beat(F_CM, 16'h0008);
    s1 = 1'b1;
    s2 = 1'b1;
    cnt = 0;
    offered = 0;
    // Scheduler sees core_reading two samples late (registered flag path).
    for (int c = 0; c < 40; c++) begin
      if (s2 && offered < 20) begin
        if (cnt < 16) begin
          in_q.push_back(16'(16'hB000 + offered));
          cnt++;
        end
        instr_loading = 1'b1;
        mess_to_core = 16'(16'hB000 + offered);
        offered++;
      end
      step();
      instr_loading = 1'b0;
      mess_to_core = '0;
      s2 = s1;
      s1 = core_reading;
      checks++;
      if (core_reading !== (cnt <= 14)) begin
        errors++;
        $display("FAIL backpressure_reading: got %b at count %0d, required %b",
                 core_reading, cnt, (cnt <= 14));
      end
    end
    checks++;
    if (err !== 1'b0 || instr_valid !== 1'b1) begin
      errors++;
      $display("FAIL backpressure_full: got err=%b valid=%b, required 0 1", err, instr_valid);
    end
    instr_ready = 1'b1;
    wait_empty("backpressure");
    checks++;
    if (instr_valid !== 1'b0) begin
      errors++;
      $display("FAIL backpressure_empty: got valid=%b, required 0", instr_valid);
    end
    pulse_done();
  endtask

  task automatic test_handover();
    instr_ready = 1'b0;
    beat(F_CM, 16'h0008);
    in_q.push_back(16'h5555);
    beat(F_IN, 16'h5555);
    in_q.push_back(16'h6666);
    beat(F_IN, 16'h6666);
    beat(F_CM, 16'h0001);
    for (int i = 0; i < 3; i++) beat(F_IN, 16'(16'hDEA0 + i));
    checks++;
    if (core_reading !== 1'b1 || core_ready !== 1'b0 || err !== 1'b0) begin
      errors++;
      $display("FAIL handover_state: got reading=%b ready=%b err=%b, required 1 0 0",
               core_reading, core_ready, err);
    end
    instr_ready = 1'b1;
    wait_empty("handover");
    pulse_done();
    checks++;
    if (core_ready !== 1'b1 || instr_valid !== 1'b0) begin
      errors++;
      $display("FAIL handover_done: got ready=%b valid=%b, required 1 0", core_ready, instr_valid);
    end
  endtask

  task automatic test_reset_error();
    instr_ready = 1'b0;
    beat(F_CM, 16'h0008);
    beat(F_IN, 16'h7777);
    beat(F_IN, 16'h7778);
    #3;
    reset_n = 1'b0;
    #1;
    rst_got = {core_ready, core_reading, r0_wr_en, r0_wr_addr, r0_wr_data, instr_valid,
               instr_data, err};
    checks++;
    if (rst_got !== RST_EXP) begin
      errors++;
      $display("FAIL midtask_reset: got %h, required %h", rst_got, RST_EXP);
    end
    step();
    reset_n = 1'b1;
    instr_ready = 1'b1;
    beat(F_CM, 16'h0008);
    beat(F_RM, 16'h0008);
    for (int i = 0; i < 8; i++) begin
      r0_q.push_back({3'(i), 16'(16'h0E00 + i)});
      beat(F_R0, 16'(16'h0E00 + i));
    end
    checks++;
    if (err !== 1'b0) begin
      errors++;
      $display("FAIL r0_full_no_err: got %b, required 0", err);
    end
    beat(F_R0, 16'h0EEE);
    step();
    checks++;
    if (err !== 1'b1) begin
      errors++;
      $display("FAIL r0_overrun_err: got %b, required 1", err);
    end
    wait_empty("r0_overrun");
    pulse_done();
    beat(F_CM, 16'h0004);
    step();
    checks++;
    if (err !== 1'b1) begin
      errors++;
      $display("FAIL err_sticky: got %b, required 1", err);
    end
    reset_n = 1'b0;
    step();
    reset_n = 1'b1;
    step();
    checks++;
    if (err !== 1'b0) begin
      errors++;
      $display("FAIL err_cleared: got %b, required 0", err);
    end
    beat(F_R0 | F_IN, 16'h0008);
    checks++;
    if (err !== 1'b1 || core_ready !== 1'b1) begin
      errors++;
      $display("FAIL multi_flag: got err=%b ready=%b, required 1 1", err, core_ready);
    end
  endtask

  initial begin
    test_reset();
    test_select_load();
    test_not_selected();
    test_r0_mask_clear();
    test_backpressure();
    test_handover();
    test_reset_error();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
